// File: rtl/fmul_share_arb_pkg.sv
// fmul_share_arb_pkg: shared constants and helpers for the shared FP multiplier arbiter.
package fmul_share_arb_pkg;
    localparam int FLEN = 64;
    localparam int NE = 11;
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fmul_share_arb_if.sv
// fmul_share_arb_if: requester, response and multiplier-side signals of the shared multiplier arbiter.
interface fmul_share_arb_if
    import fmul_share_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int FLEN = fmul_share_arb_pkg::FLEN
);
    logic [N-1:0] req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [N*FLEN-1:0] req_a, req_b, rsp_res;
    logic mul_up_vld, mul_down_vld, mul_err;
    logic [FLEN-1:0] mul_a, mul_b, mul_res;
    modport master (
        output req_vld, req_a, req_b, rsp_rdy, mul_down_vld, mul_res,
        input req_rdy, rsp_vld, rsp_res, mul_up_vld, mul_a, mul_b, mul_err
    );
    modport slave (
        input req_vld, req_a, req_b, rsp_rdy, mul_down_vld, mul_res,
        output req_rdy, rsp_vld, rsp_res, mul_up_vld, mul_a, mul_b, mul_err
    );
endinterface

// File: rtl/fmul_rsp_fifo.sv
// fmul_rsp_fifo: per-requester result FIFO; head is read straight from the storage registers.
module fmul_rsp_fifo
    import fmul_share_arb_pkg::*;
#(
    parameter int W = FLEN,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign empty = cnt == '0;
    assign full = cnt == (AW+1)'(DEPTH);
    assign head = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= do_pop ? rp + 1'b1 : rp;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fmul_share_arb.sv
// fmul_share_arb: round-robin sharing of one fixed-latency pipelined FP multiplier among N requesters,
// with a tag pipeline steering results into credit-protected per-requester response FIFOs.
module fmul_share_arb
    import fmul_share_arb_pkg::*;
#(
    parameter int FLEN = fmul_share_arb_pkg::FLEN,
    parameter int N = 2,
    parameter int MUL_LAT = 3,
    parameter int RSP_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    fmul_share_arb_if.slave bus
);
    localparam int IDW = id_w(N);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int QW = $clog2(MUL_LAT + 1);
    logic [IDW-1:0] ptr, gid, j;
    logic [N-1:0] elig, grant, push, pop, full, empty;
    logic [CW-1:0] cnt [N];
    logic tv [MUL_LAT];
    logic [IDW-1:0] tid [MUL_LAT];
    logic [QW-1:0] quiet;
    logic found, err;
    always_comb begin
        found = 1'b0;
        grant = '0;
        gid = ptr;
        j = '0;
        elig = '0;
        for (int i = 0; i < N; i++)
            elig[i] = bus.req_vld[i] & ~full[i] & ~rst & (cnt[i] < CW'(RSP_DEPTH));
        for (int k = 1; k <= N; k++) begin
            j = IDW'((int'(ptr) + k) % N);
            if (!found && elig[j]) begin
                found = 1'b1;
                grant[j] = 1'b1;
                gid = j;
            end
        end
    end
    assign bus.req_rdy = grant;
    assign bus.mul_up_vld = |grant;
    assign bus.mul_a = bus.req_a[gid*FLEN +: FLEN];
    assign bus.mul_b = bus.req_b[gid*FLEN +: FLEN];
    assign bus.rsp_vld = ~empty;
    assign bus.mul_err = err;
    always_ff @(posedge clk) begin
        if (rst) ptr <= IDW'(N - 1);
        else if (|grant) ptr <= gid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tv[k] <= 1'b0;
                tid[k] <= '0;
            end
        end else begin
            tv[0] <= |grant;
            tid[0] <= gid;
            for (int k = 1; k < MUL_LAT; k++) begin
                tv[k] <= tv[k-1];
                tid[k] <= tid[k-1];
            end
        end
    end
    // Results of work issued before reset can still emerge for MUL_LAT-1 cycles; they are not errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
            quiet <= QW'(MUL_LAT - 1);
        end else begin
            if (quiet != '0) quiet <= quiet - 1'b1;
            if (quiet == '0 && bus.mul_down_vld != tv[MUL_LAT-1]) err <= 1'b1;
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_rsp
        assign pop[g] = bus.rsp_vld[g] & bus.rsp_rdy[g];
        assign push[g] = tv[MUL_LAT-1] && tid[MUL_LAT-1] == IDW'(g);
        always_ff @(posedge clk) begin
            if (rst) cnt[g] <= '0;
            else cnt[g] <= cnt[g] + CW'(grant[g]) - CW'(pop[g]);
        end
        fmul_rsp_fifo #(.W(FLEN), .DEPTH(RSP_DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(push[g]),
            .pop(pop[g]),
            .din(bus.mul_res),
            .head(bus.rsp_res[g*FLEN +: FLEN]),
            .empty(empty[g]),
            .full(full[g])
        );
    end
endmodule
